// File: rtl/hdr_strip_vlg.sv
// hdr_strip_vlg: captures a fixed-length header from a framed byte stream
// and forwards (or discards) the remaining payload bytes.
// Optional feature: define HDR_STRIP_CHSUM_EN to build the 16-bit
// ones'-complement header checksum behind chsum_ok; without it chsum_ok is 0.
module hdr_strip_vlg #(
    parameter int HDR_LEN = 20,
    parameter int PLD_EN  = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [7:0]           in_dat,
    input  logic                 in_val,
    input  logic                 in_sof,
    input  logic                 in_eof,
    output logic [HDR_LEN*8-1:0] hdr,
    output logic                 hdr_val,
    output logic [7:0]           out_dat,
    output logic                 out_val,
    output logic                 out_sof,
    output logic                 out_eof,
    output logic                 err,
    output logic                 chsum_ok
);

    localparam int            CW       = $clog2(HDR_LEN + 1);
    localparam logic [CW-1:0] CNT_ZERO = CW'(0);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);
    localparam logic [CW-1:0] CNT_LAST = CW'(HDR_LEN - 1);
    localparam logic [CW-1:0] CNT_FULL = CW'(HDR_LEN);
    localparam logic          PLD_ON   = (PLD_EN != 0);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HDR  = 2'd1,
        PLD  = 2'd2
    } state_t;

    state_t               state_r;
    state_t               state_nxt_s;
    logic [CW-1:0]        cnt_r;
    logic [CW-1:0]        cnt_nxt_s;
    logic                 first_r;       // next payload byte is the packet's first
    logic                 first_nxt_s;
    logic [HDR_LEN*8-1:0] hdr_r;

    logic                 hdr_wr_s;      // write in_dat into header slot hdr_idx_s
    logic [CW-1:0]        hdr_idx_s;
    logic                 sof_start_s;   // byte accepted as header byte 0
    logic                 hdr_done_s;    // last header byte accepted
    logic                 err_nxt_s;
    logic                 out_val_nxt_s;
    logic                 out_sof_nxt_s;
    logic                 out_eof_nxt_s;

    logic                 hdr_val_r;
    logic                 err_r;
    logic [7:0]           out_dat_r;
    logic                 out_val_r;
    logic                 out_sof_r;
    logic                 out_eof_r;

    // State, byte counter and first-payload flag registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= IDLE;
            cnt_r   <= CNT_ZERO;
            first_r <= 1'b0;
        end else begin
            state_r <= state_nxt_s;
            cnt_r   <= cnt_nxt_s;
            first_r <= first_nxt_s;
        end
    end

    // Next-state and counter decode; a stray sof always restarts header capture
    always_comb begin
        state_nxt_s = state_r;
        cnt_nxt_s   = cnt_r;
        first_nxt_s = first_r;
        if (in_val) begin
            case (state_r)
                IDLE: begin
                    if (in_sof && !in_eof) begin
                        state_nxt_s = HDR;
                        cnt_nxt_s   = CNT_ONE;
                    end else begin
                        state_nxt_s = IDLE;
                        cnt_nxt_s   = CNT_ZERO;
                    end
                end
                HDR: begin
                    if (in_sof) begin
                        state_nxt_s = in_eof ? IDLE : HDR;
                        cnt_nxt_s   = in_eof ? CNT_ZERO : CNT_ONE;
                    end else if (cnt_r >= CNT_LAST) begin
                        state_nxt_s = in_eof ? IDLE : PLD;
                        cnt_nxt_s   = in_eof ? CNT_ZERO : CNT_FULL;
                        first_nxt_s = !in_eof;
                    end else if (in_eof) begin
                        state_nxt_s = IDLE;
                        cnt_nxt_s   = CNT_ZERO;
                    end else begin
                        cnt_nxt_s   = cnt_r + CNT_ONE;
                    end
                end
                PLD: begin
                    first_nxt_s = 1'b0;
                    if (in_sof) begin
                        state_nxt_s = in_eof ? IDLE : HDR;
                        cnt_nxt_s   = in_eof ? CNT_ZERO : CNT_ONE;
                    end else if (in_eof) begin
                        state_nxt_s = IDLE;
                        cnt_nxt_s   = CNT_ZERO;
                    end else begin
                        state_nxt_s = PLD;
                    end
                end
                default: begin
                    state_nxt_s = IDLE;
                    cnt_nxt_s   = CNT_ZERO;
                    first_nxt_s = 1'b0;
                end
            endcase
        end else begin
            state_nxt_s = state_r;
        end
    end

    // Output and datapath-control decode for the byte on the input this cycle
    always_comb begin
        hdr_wr_s      = 1'b0;
        sof_start_s   = 1'b0;
        hdr_done_s    = 1'b0;
        err_nxt_s     = 1'b0;
        out_val_nxt_s = 1'b0;
        out_sof_nxt_s = 1'b0;
        out_eof_nxt_s = 1'b0;
        if (in_val) begin
            case (state_r)
                IDLE: begin
                    if (in_sof) begin
                        hdr_wr_s    = 1'b1;
                        sof_start_s = 1'b1;
                        err_nxt_s   = in_eof;
                    end else begin
                        hdr_wr_s    = 1'b0;
                    end
                end
                HDR: begin
                    hdr_wr_s = 1'b1;
                    if (in_sof) begin
                        sof_start_s = 1'b1;
                        err_nxt_s   = 1'b1;
                    end else if (cnt_r >= CNT_LAST) begin
                        hdr_done_s  = 1'b1;
                    end else begin
                        err_nxt_s   = in_eof;
                    end
                end
                PLD: begin
                    if (in_sof) begin
                        hdr_wr_s    = 1'b1;
                        sof_start_s = 1'b1;
                        err_nxt_s   = 1'b1;
                    end else begin
                        out_val_nxt_s = PLD_ON;
                        out_sof_nxt_s = PLD_ON & first_r;
                        out_eof_nxt_s = PLD_ON & in_eof;
                    end
                end
                default: begin
                    hdr_wr_s = 1'b0;
                end
            endcase
        end else begin
            hdr_wr_s = 1'b0;
        end
    end

    assign hdr_idx_s = sof_start_s ? CNT_ZERO : cnt_r;

    // Header capture: byte index i lands in slot i counted from the MSB
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hdr_r <= '0;
        end else if (hdr_wr_s) begin
            for (int i = 0; i < HDR_LEN; i++) begin
                if (hdr_idx_s == CW'(i)) begin
                    hdr_r[(HDR_LEN-1-i)*8 +: 8] <= in_dat;
                end
            end
        end else begin
            hdr_r <= hdr_r;
        end
    end

    // Registered status pulses and payload stream
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hdr_val_r <= 1'b0;
            err_r     <= 1'b0;
            out_dat_r <= 8'h00;
            out_val_r <= 1'b0;
            out_sof_r <= 1'b0;
            out_eof_r <= 1'b0;
        end else begin
            hdr_val_r <= hdr_done_s;
            err_r     <= err_nxt_s;
            out_val_r <= out_val_nxt_s;
            out_sof_r <= out_sof_nxt_s;
            out_eof_r <= out_eof_nxt_s;
            if (out_val_nxt_s) begin
                out_dat_r <= in_dat;
            end else begin
                out_dat_r <= out_dat_r;
            end
        end
    end

`ifdef HDR_STRIP_CHSUM_EN
    // 16-bit ones'-complement add with end-around carry
    function automatic logic [15:0] oc_add(input logic [15:0] a, input logic [15:0] b);
        logic [16:0] s;
        s = {1'b0, a} + {1'b0, b};
        return s[15:0] + {15'h0000, s[16]};
    endfunction

    logic [15:0] acc_r;
    logic [15:0] word_s;
    logic [15:0] acc_sum_s;
    logic        chsum_ok_r;

    // Place the byte in the high half for even header indices, low half for odd
    always_comb begin
        if (hdr_idx_s[0]) begin
            word_s = {8'h00, in_dat};
        end else begin
            word_s = {in_dat, 8'h00};
        end
        acc_sum_s = oc_add(sof_start_s ? 16'h0000 : acc_r, word_s);
    end

    // Running header sum, restarted by every header byte 0
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_r      <= 16'h0000;
            chsum_ok_r <= 1'b0;
        end else begin
            chsum_ok_r <= hdr_done_s & (acc_sum_s == 16'hFFFF);
            if (hdr_wr_s) begin
                acc_r <= acc_sum_s;
            end else begin
                acc_r <= acc_r;
            end
        end
    end

    assign chsum_ok = chsum_ok_r;
`else
    assign chsum_ok = 1'b0;
`endif

    assign hdr     = hdr_r;
    assign hdr_val = hdr_val_r;
    assign err     = err_r;
    assign out_dat = out_dat_r;
    assign out_val = out_val_r;
    assign out_sof = out_sof_r;
    assign out_eof = out_eof_r;

endmodule

// File: tb/tb_hdr_strip_vlg.sv
// Directed bench for hdr_strip_vlg: an 8-byte-header instance (payload on),
// an 8-byte-header instance with payload discarded, and a 20-byte instance,
// all fed from one shared input stream.
module tb_hdr_strip_vlg;

    logic        clk;
    logic        rst_n;
    logic [7:0]  in_dat;
    logic        in_val;
    logic        in_sof;
    logic        in_eof;

    logic [63:0]  a_hdr;
    logic         a_hdr_val, a_out_val, a_out_sof, a_out_eof, a_err, a_chsum_ok;
    logic [7:0]   a_out_dat;
    logic [63:0]  n_hdr;
    logic         n_hdr_val, n_out_val, n_out_sof, n_out_eof, n_err, n_chsum_ok;
    logic [7:0]   n_out_dat;
    logic [159:0] b_hdr;
    logic         b_hdr_val, b_out_val, b_out_sof, b_out_eof, b_err, b_chsum_ok;
    logic [7:0]   b_out_dat;

    int n_checks;
    int n_fail;

    hdr_strip_vlg #(.HDR_LEN(8), .PLD_EN(1)) dut_a (
        .clk(clk), .rst_n(rst_n), .in_dat(in_dat), .in_val(in_val), .in_sof(in_sof), .in_eof(in_eof),
        .hdr(a_hdr), .hdr_val(a_hdr_val), .out_dat(a_out_dat), .out_val(a_out_val),
        .out_sof(a_out_sof), .out_eof(a_out_eof), .err(a_err), .chsum_ok(a_chsum_ok)
    );

    hdr_strip_vlg #(.HDR_LEN(8), .PLD_EN(0)) dut_n (
        .clk(clk), .rst_n(rst_n), .in_dat(in_dat), .in_val(in_val), .in_sof(in_sof), .in_eof(in_eof),
        .hdr(n_hdr), .hdr_val(n_hdr_val), .out_dat(n_out_dat), .out_val(n_out_val),
        .out_sof(n_out_sof), .out_eof(n_out_eof), .err(n_err), .chsum_ok(n_chsum_ok)
    );

    hdr_strip_vlg #(.HDR_LEN(20), .PLD_EN(1)) dut_b (
        .clk(clk), .rst_n(rst_n), .in_dat(in_dat), .in_val(in_val), .in_sof(in_sof), .in_eof(in_eof),
        .hdr(b_hdr), .hdr_val(b_hdr_val), .out_dat(b_out_dat), .out_val(b_out_val),
        .out_sof(b_out_sof), .out_eof(b_out_eof), .err(b_err), .chsum_ok(b_chsum_ok)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Present one input beat, let the next rising edge take it, then settle
    task automatic drive(input logic [7:0] d, input logic v, input logic s, input logic e);
        in_dat = d;
        in_val = v;
        in_sof = s;
        in_eof = e;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        repeat (3) @(posedge clk);
        #1;
        n_checks++;
        if ({a_hdr_val, a_err, a_out_val, a_out_sof, a_out_eof, a_chsum_ok, a_out_dat} !== 14'h0) begin
            n_fail++; $display("FAIL reset_a_outs got %h exp 0", {a_hdr_val, a_err, a_out_val, a_out_sof, a_out_eof, a_chsum_ok, a_out_dat});
        end
        n_checks++;
        if (a_hdr !== 64'h0) begin n_fail++; $display("FAIL reset_a_hdr got %h exp 0", a_hdr); end
        n_checks++;
        if ({b_hdr_val, b_err, b_out_val, b_out_sof, b_out_eof, b_chsum_ok, b_out_dat} !== 14'h0) begin
            n_fail++; $display("FAIL reset_b_outs got %h exp 0", {b_hdr_val, b_err, b_out_val, b_out_sof, b_out_eof, b_chsum_ok, b_out_dat});
        end
        n_checks++;
        if (b_hdr !== 160'h0) begin n_fail++; $display("FAIL reset_b_hdr got %h exp 0", b_hdr); end
        rst_n = 1'b1;
        drive(8'h00, 1'b0, 1'b0, 1'b0);
    endtask

    // 8-byte header with checksum word in bytes 6..7, two payload bytes
    task automatic test_chsum(input logic bad);
        logic [7:0]  pk [0:9];
        logic [63:0] exp_hdr;
        logic        exp_ok;
        logic [2:0]  exp_fl;
        for (int k = 0; k < 8; k++) pk[k] = 8'h00;
        pk[6] = 8'hFF;
        pk[7] = bad ? 8'hFE : 8'hFF;
        pk[8] = 8'hAA;
        pk[9] = 8'hBB;
        exp_hdr = bad ? 64'h0000_0000_0000_FFFE : 64'h0000_0000_0000_FFFF;
`ifdef HDR_STRIP_CHSUM_EN
        exp_ok = !bad;
`else
        exp_ok = 1'b0;
`endif
        for (int k = 0; k < 10; k++) begin
            drive(pk[k], 1'b1, k == 0, k == 9);
            exp_fl = (k == 8) ? 3'b110 : ((k == 9) ? 3'b101 : 3'b000);
            n_checks++;
            if ({a_hdr_val, a_err} !== {k == 7, 1'b0}) begin
                n_fail++; $display("FAIL chsum_a_hv_err k=%0d got %b exp %b", k, {a_hdr_val, a_err}, {k == 7, 1'b0});
            end
            n_checks++;
            if ({a_out_val, a_out_sof, a_out_eof} !== exp_fl) begin
                n_fail++; $display("FAIL chsum_a_out_flags k=%0d got %b exp %b", k, {a_out_val, a_out_sof, a_out_eof}, exp_fl);
            end
            n_checks++;
            if ({n_hdr_val, n_out_val, n_out_sof, n_out_eof} !== {k == 7, 3'b000}) begin
                n_fail++; $display("FAIL chsum_n_flags k=%0d got %b exp %b", k, {n_hdr_val, n_out_val, n_out_sof, n_out_eof}, {k == 7, 3'b000});
            end
            if (k >= 8) begin
                n_checks++;
                if (a_out_dat !== pk[k]) begin n_fail++; $display("FAIL chsum_a_out_dat k=%0d got %h exp %h", k, a_out_dat, pk[k]); end
            end
            if (k == 7) begin
                n_checks++;
                if (a_hdr !== exp_hdr) begin n_fail++; $display("FAIL chsum_a_hdr got %h exp %h", a_hdr, exp_hdr); end
                n_checks++;
                if (a_chsum_ok !== exp_ok) begin n_fail++; $display("FAIL chsum_ok bad=%0b got %b exp %b", bad, a_chsum_ok, exp_ok); end
                n_checks++;
                if (n_hdr !== exp_hdr) begin n_fail++; $display("FAIL chsum_n_hdr got %h exp %h", n_hdr, exp_hdr); end
            end
        end
        drive(8'h00, 1'b0, 1'b0, 1'b0);
        n_checks++;
        if ({a_out_val, a_hdr_val, a_err} !== 3'b000) begin
            n_fail++; $display("FAIL chsum_a_idle got %b exp 000", {a_out_val, a_hdr_val, a_err});
        end
    endtask

    // eof on byte 12 of a 20-byte header, then stray non-sof bytes in IDLE
    task automatic test_runt();
        for (int k = 0; k < 13; k++) begin
            drive(8'h30 + 8'(k), 1'b1, k == 0, k == 12);
            n_checks++;
            if ({b_hdr_val, b_out_val, b_err} !== {2'b00, k == 12}) begin
                n_fail++; $display("FAIL runt_b k=%0d got %b exp %b", k, {b_hdr_val, b_out_val, b_err}, {2'b00, k == 12});
            end
        end
        for (int k = 0; k < 3; k++) begin
            drive(8'h77, 1'b1, 1'b0, k == 2);
            n_checks++;
            if ({b_hdr_val, b_out_val, b_err, a_hdr_val, a_out_val, a_err} !== 6'b000000) begin
                n_fail++; $display("FAIL runt_stray k=%0d got %b exp 000000", k, {b_hdr_val, b_out_val, b_err, a_hdr_val, a_out_val, a_err});
            end
        end
    endtask

    // Packet A aborted by sof on its payload byte 3; packet B completes
    task automatic test_sof_abort();
        logic [7:0]   d [0:44];
        logic         s [0:44];
        logic         e [0:44];
        logic [159:0] exp_a;
        logic [159:0] exp_b;
        logic [4:0]   exp_fl;
        for (int k = 0; k < 45; k++) begin s[k] = 1'b0; e[k] = 1'b0; end
        for (int k = 0; k < 20; k++) begin
            d[k]      = 8'h40 + 8'(k);
            d[23 + k] = 8'h80 + 8'(k);
            exp_a[(19-k)*8 +: 8] = 8'h40 + 8'(k);
            exp_b[(19-k)*8 +: 8] = 8'h80 + 8'(k);
        end
        d[20] = 8'hC0; d[21] = 8'hC1; d[22] = 8'hC2;
        d[43] = 8'hD0; d[44] = 8'hD1;
        s[0] = 1'b1; s[23] = 1'b1; e[44] = 1'b1;
        for (int k = 0; k < 45; k++) begin
            drive(d[k], 1'b1, s[k], e[k]);
            exp_fl = {k == 19 || k == 42, k == 23, (k >= 20 && k <= 22) || k >= 43, k == 20 || k == 43, k == 44};
            n_checks++;
            if ({b_hdr_val, b_err, b_out_val, b_out_sof, b_out_eof} !== exp_fl) begin
                n_fail++; $display("FAIL abort_flags k=%0d got %b exp %b", k, {b_hdr_val, b_err, b_out_val, b_out_sof, b_out_eof}, exp_fl);
            end
            if (exp_fl[2]) begin
                n_checks++;
                if (b_out_dat !== d[k]) begin n_fail++; $display("FAIL abort_dat k=%0d got %h exp %h", k, b_out_dat, d[k]); end
            end
            if (k == 22) begin
                n_checks++;
                if (b_hdr !== exp_a) begin n_fail++; $display("FAIL abort_hdr_a got %h exp %h", b_hdr, exp_a); end
            end
            if (k == 42) begin
                n_checks++;
                if (b_hdr !== exp_b) begin n_fail++; $display("FAIL abort_hdr_b got %h exp %h", b_hdr, exp_b); end
            end
        end
    endtask

    // 20-byte header plus 4 payload bytes with in_val low on alternate cycles
    task automatic test_stall();
        logic [7:0]   d [0:23];
        logic [159:0] exp_h;
        logic [4:0]   exp_fl;
        for (int k = 0; k < 20; k++) begin
            d[k] = 8'h60 + 8'(k);
            exp_h[(19-k)*8 +: 8] = 8'h60 + 8'(k);
        end
        d[20] = 8'hE0; d[21] = 8'hE1; d[22] = 8'hE2; d[23] = 8'hE3;
        for (int k = 0; k < 24; k++) begin
            drive(8'hEE, 1'b0, 1'b1, 1'b1);
            n_checks++;
            if ({b_hdr_val, b_err, b_out_val} !== 3'b000) begin
                n_fail++; $display("FAIL stall_gap k=%0d got %b exp 000", k, {b_hdr_val, b_err, b_out_val});
            end
            drive(d[k], 1'b1, k == 0, k == 23);
            exp_fl = {k == 19, 1'b0, k >= 20, k == 20, k == 23};
            n_checks++;
            if ({b_hdr_val, b_err, b_out_val, b_out_sof, b_out_eof} !== exp_fl) begin
                n_fail++; $display("FAIL stall_flags k=%0d got %b exp %b", k, {b_hdr_val, b_err, b_out_val, b_out_sof, b_out_eof}, exp_fl);
            end
            if (k >= 20) begin
                n_checks++;
                if (b_out_dat !== d[k]) begin n_fail++; $display("FAIL stall_dat k=%0d got %h exp %h", k, b_out_dat, d[k]); end
            end
            if (k == 19 || k == 23) begin
                n_checks++;
                if (b_hdr !== exp_h) begin n_fail++; $display("FAIL stall_hdr k=%0d got %h exp %h", k, b_hdr, exp_h); end
            end
        end
    endtask

    // Reset during header byte 5, then stray bytes and a clean packet
    task automatic test_reset_mid();
        logic [159:0] exp_h;
        logic [7:0]   d [0:21];
        logic [4:0]   exp_fl;
        for (int k = 0; k < 5; k++) drive(8'h20 + 8'(k), 1'b1, k == 0, 1'b0);
        in_dat = 8'h25; in_val = 1'b1; in_sof = 1'b0; in_eof = 1'b0;
        rst_n = 1'b0;
        #2;
        n_checks++;
        if (b_hdr !== 160'h0) begin n_fail++; $display("FAIL rstmid_async_hdr got %h exp 0", b_hdr); end
        n_checks++;
        if ({a_out_dat, a_hdr, b_hdr_val, b_err, b_out_val, b_out_sof, b_out_eof, b_out_dat} !== 85'h0) begin
            n_fail++; $display("FAIL rstmid_async_outs got %h exp 0", {a_out_dat, a_hdr, b_hdr_val, b_err, b_out_val, b_out_sof, b_out_eof, b_out_dat});
        end
        repeat (2) @(posedge clk);
        #1;
        n_checks++;
        if ({b_hdr, b_hdr_val, b_err, b_out_val, b_out_sof, b_out_eof, b_chsum_ok, b_out_dat} !== 174'h0) begin
            n_fail++; $display("FAIL rstmid_held got %h exp 0", {b_hdr, b_hdr_val, b_err, b_out_val, b_out_sof, b_out_eof, b_chsum_ok, b_out_dat});
        end
        rst_n = 1'b1;
        drive(8'h00, 1'b0, 1'b0, 1'b0);
        for (int k = 0; k < 2; k++) begin
            drive(8'h26 + 8'(k), 1'b1, 1'b0, k == 1);
            n_checks++;
            if ({b_hdr_val, b_err, b_out_val} !== 3'b000) begin
                n_fail++; $display("FAIL rstmid_stray k=%0d got %b exp 000", k, {b_hdr_val, b_err, b_out_val});
            end
        end
        for (int k = 0; k < 20; k++) begin
            d[k] = 8'h50 + 8'(k);
            exp_h[(19-k)*8 +: 8] = 8'h50 + 8'(k);
        end
        d[20] = 8'hF0; d[21] = 8'hF1;
        for (int k = 0; k < 22; k++) begin
            drive(d[k], 1'b1, k == 0, k == 21);
            exp_fl = {k == 19, 1'b0, k >= 20, k == 20, k == 21};
            n_checks++;
            if ({b_hdr_val, b_err, b_out_val, b_out_sof, b_out_eof} !== exp_fl) begin
                n_fail++; $display("FAIL rstmid_flags k=%0d got %b exp %b", k, {b_hdr_val, b_err, b_out_val, b_out_sof, b_out_eof}, exp_fl);
            end
            if (k >= 20) begin
                n_checks++;
                if (b_out_dat !== d[k]) begin n_fail++; $display("FAIL rstmid_dat k=%0d got %h exp %h", k, b_out_dat, d[k]); end
            end
            if (k == 19) begin
                n_checks++;
                if (b_hdr !== exp_h) begin n_fail++; $display("FAIL rstmid_hdr got %h exp %h", b_hdr, exp_h); end
            end
        end
        drive(8'h00, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        rst_n    = 1'b0;
        in_dat   = 8'h00;
        in_val   = 1'b0;
        in_sof   = 1'b0;
        in_eof   = 1'b0;
        test_reset();
        test_chsum(1'b0);
        test_chsum(1'b1);
        test_runt();
        test_sof_abort();
        test_stall();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/hdr_strip_vlg.md
HDR_STRIP_VLG -- requirements
Module: hdr_strip_vlg

Interface
REQ-001 SHALL have parameter HDR_LEN, default 20, meaning header length in bytes; legal range 2..64, even values only.
REQ-002 SHALL have parameter PLD_EN, default 1, meaning 1 forwards the payload and 0 discards it.
REQ-003 SHALL have port clk, input, 1 bit, sole clock; all logic on the rising edge.
REQ-004 SHALL have port rst_n, input, 1 bit, reset; asynchronous, active-low.
REQ-005 SHALL have ports in_dat (input, 8 bits), in_val, in_sof and in_eof (inputs, 1 bit each), carrying the byte stream; each byte is accepted on a cycle with in_val=1.
REQ-006 SHALL have port hdr, output, HDR_LEN*8 bits, holding the captured header in network order.
REQ-007 SHALL have port hdr_val, output, 1 bit, a one-cycle pulse when the header is complete.
REQ-008 SHALL have ports out_dat (output, 8 bits), out_val, out_sof and out_eof (outputs, 1 bit each), carrying the payload stream.
REQ-009 SHALL have port err, output, 1 bit, a one-cycle pulse on a malformed packet.
REQ-010 SHALL have port chsum_ok, output, 1 bit, header checksum pass flag, qualified by hdr_val.

Function
REQ-011 SHALL implement the FSM states IDLE, HDR and PLD, with a byte counter cnt of width $clog2(HDR_LEN+1).
REQ-012 SHALL, in IDLE on in_val & in_sof, store the byte in hdr[HDR_LEN*8-1 -: 8], set cnt=1 and go to HDR.
REQ-013 SHALL ignore bytes arriving in IDLE without in_sof: no output, no err.
REQ-014 SHALL, in HDR, store each accepted byte at position cnt (MSB first) and increment cnt; in_val=0 stalls with no state change.
REQ-015 SHALL, on acceptance of byte HDR_LEN-1, pulse hdr_val on the next cycle and go to PLD, or to IDLE if in_eof is set on that byte.
REQ-016 SHALL hold hdr stable from the hdr_val pulse until the next accepted in_sof.
REQ-017 SHALL, in PLD with PLD_EN=1, register each accepted byte to out_dat/out_val with 1-cycle latency.
REQ-018 SHALL assert out_sof on the first payload byte and out_eof together with the byte that carried in_eof, then return to IDLE.
REQ-019 SHALL, with PLD_EN=0, hold out_val at 0 while still tracking in_eof to return to IDLE.
REQ-020 SHALL, on in_eof in HDR before byte HDR_LEN-1, pulse err, not assert hdr_val, and return to IDLE (runt).
REQ-021 SHALL, on in_sof in HDR or PLD, pulse err, emit no out_eof for the aborted packet, and restart capture with that byte as header byte 0 (cnt=1, state HDR).
REQ-022 SHALL, when in_sof and in_eof occur on the same byte and HDR_LEN>1, treat it as a runt (REQ-020).
REQ-023 SHALL ensure cnt never exceeds HDR_LEN and never wraps.

Reset
REQ-024 SHALL, while rst_n=0 and regardless of clk, force state IDLE, cnt=0, hdr=0, and hdr_val, err, out_val, out_sof, out_eof, out_dat and chsum_ok all to 0.
REQ-025 SHALL drop a packet in progress when reset is asserted; after release the block SHALL wait for a new in_sof and SHALL NOT raise err for the lost packet.

Configuration
REQ-026 SHALL, when HDR_STRIP_CHSUM_EN is defined, accumulate a 16-bit ones'-complement sum with end-around carry over the header as big-endian 16-bit words (byte 2k high, byte 2k+1 low).
REQ-027 SHALL, with HDR_STRIP_CHSUM_EN defined, set chsum_ok=1 in the hdr_val cycle iff the folded sum equals 16'hFFFF, and clear the accumulator on each accepted in_sof.
REQ-028 SHALL, when HDR_STRIP_CHSUM_EN is not defined, keep the chsum_ok port and tie it to 0, with no accumulator logic synthesized.

Verification
REQ-029 SHALL cover: HDR_LEN=8, CHSUM on, bytes 00 00 00 00 00 00 FF FF AA BB (eof on BB) -> hdr=64'h0000_0000_0000_FFFF, hdr_val=1, chsum_ok=1, out AA (sof) then BB (eof), each 1 cycle after input.
REQ-030 SHALL cover: the same stimulus with byte 7 = FE -> chsum_ok=0, and payload still forwarded.
REQ-031 SHALL cover: HDR_LEN=20, eof on byte 12 -> err pulse, no hdr_val, no out_val, and FSM back in IDLE.
REQ-032 SHALL cover: in_sof at payload byte 3 of an active packet -> err pulse, no out_eof, and the new header captured from that byte.
REQ-033 SHALL cover: in_val toggled 0/1 on alternate cycles through a 20-byte header plus 4-byte payload -> same hdr and payload as the unstalled run.
REQ-034 SHALL cover: rst_n pulsed low at header byte 5, then a clean packet -> all outputs 0 during reset, no err, and the second packet parsed correctly.
